// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, sequencer
// states and the control word that carries one bit per datapath strobe.
package cpu_pkg;

    localparam int OP_W_DEF   = 5;
    localparam int STEP_W_DEF = 3;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LDA = 5'h01;
    localparam logic [4:0] OP_STA = 5'h02;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_JMP = 5'h05;
    localparam logic [4:0] OP_JZ  = 5'h06;
    localparam logic [4:0] OP_LDI = 5'h07;
    localparam logic [4:0] OP_HLT = 5'h1F;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic pc_inc;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic acc_in;
        logic acc_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Everything that can drive the shared bus, for the one-driver check.
    function automatic logic [4:0] bus_drivers(input ctrl_t c);
        return {c.pc_out, c.ram_out, c.ir_out, c.acc_out, c.alu_out};
    endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational microcode: {OpCode, Step, ZeroFlag} -> control word, plus
// last-step, halt-request and illegal-opcode flags for the sequencer.
module cpu_control_decode
    import cpu_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic [OP_W-1:0]   OpCode,
    input  logic [STEP_W-1:0] Step,
    input  logic              ZeroFlag,
    output ctrl_t             ctrl,
    output logic              last_step,
    output logic              halt_req,
    output logic              illegal
);

    localparam logic [STEP_W-1:0] T0 = '0;
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);

    always_comb begin
        ctrl      = CTRL_NONE;
        last_step = 1'b0;
        halt_req  = 1'b0;
        illegal   = 1'b0;
        case (Step)
            T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
            end
            T1: begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            default: begin
                // Every branch ends at its final step, so Step can never run past T4.
                case (OpCode)
                    OP_W'(OP_NOP): last_step = 1'b1;
                    OP_W'(OP_LDA), OP_W'(OP_STA): begin
                        if (Step == T2) begin
                            ctrl.ir_out = 1'b1;
                            ctrl.mar_in = 1'b1;
                        end else begin
                            ctrl.ram_out = (OpCode == OP_W'(OP_LDA));
                            ctrl.acc_in  = (OpCode == OP_W'(OP_LDA));
                            ctrl.acc_out = (OpCode == OP_W'(OP_STA));
                            ctrl.ram_in  = (OpCode == OP_W'(OP_STA));
                            last_step    = 1'b1;
                        end
                    end
                    OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        if (Step == T2) begin
                            ctrl.ir_out = 1'b1;
                            ctrl.mar_in = 1'b1;
                        end else if (Step == T3) begin
                            ctrl.ram_out = 1'b1;
                            ctrl.b_in    = 1'b1;
                        end else begin
                            ctrl.alu_out  = 1'b1;
                            ctrl.acc_in   = 1'b1;
                            ctrl.flags_in = 1'b1;
                            ctrl.alu_sub  = (OpCode == OP_W'(OP_SUB));
                            last_step     = 1'b1;
                        end
                    end
                    OP_W'(OP_JMP): begin
                        ctrl.ir_out = 1'b1;
                        ctrl.pc_in  = 1'b1;
                        last_step   = 1'b1;
                    end
                    OP_W'(OP_JZ): begin
                        ctrl.ir_out = ZeroFlag;
                        ctrl.pc_in  = ZeroFlag;
                        last_step   = 1'b1;
                    end
                    OP_W'(OP_LDI): begin
                        ctrl.ir_out = 1'b1;
                        ctrl.acc_in = 1'b1;
                        last_step   = 1'b1;
                    end
                    OP_W'(OP_HLT): begin
                        halt_req  = 1'b1;
                        last_step = 1'b1;
                    end
                    default: begin
                        illegal   = (Step == T2);
                        last_step = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer: owns the FETCH/HALT state, the T-state
// counter, Run gating at instruction boundaries and reset forcing of strobes.
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic [OP_W-1:0]   OpCode,
    input  logic              ZeroFlag,
    output logic              PcOut,
    output logic              PcIn,
    output logic              PcInc,
    output logic              MarIn,
    output logic              RamOut,
    output logic              RamIn,
    output logic              InstructionRegIn,
    output logic              InstructionRegOut,
    output logic              AccIn,
    output logic              AccOut,
    output logic              BIn,
    output logic              AluOut,
    output logic              AluSub,
    output logic              FlagsIn,
    output logic [STEP_W-1:0] Step,
    output logic              Halted,
    output logic              IllegalOp
);

    localparam logic [STEP_W-1:0] T0 = '0;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    ctrl_t             dec_ctrl, ctrl;
    logic              dec_last, dec_halt, dec_illegal;
    logic              illegal_d;

    cpu_control_decode #(
        .OP_W   (OP_W),
        .STEP_W (STEP_W)
    ) u_decode (
        .OpCode    (OpCode),
        .Step      (step_q),
        .ZeroFlag  (ZeroFlag),
        .ctrl      (dec_ctrl),
        .last_step (dec_last),
        .halt_req  (dec_halt),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ctrl      = CTRL_NONE;
        illegal_d = 1'b0;
        case (state_q)
            FETCH: begin
                // Run only matters at T0; a started instruction always completes.
                if (step_q != T0 || Run) begin
                    ctrl      = dec_ctrl;
                    illegal_d = dec_illegal;
                    if (dec_halt) begin
                        state_d = HALT;
                        step_d  = T0;
                    end else if (dec_last) begin
                        step_d = T0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            HALT: step_d = T0;
            default: begin
                state_d = FETCH;
                step_d  = T0;
            end
        endcase
        // Reset is asynchronous; strobes must drop the moment it rises.
        if (Rst) begin
            ctrl      = CTRL_NONE;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= FETCH;
            step_q  <= T0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign PcOut             = ctrl.pc_out;
    assign PcIn              = ctrl.pc_in;
    assign PcInc             = ctrl.pc_inc;
    assign MarIn             = ctrl.mar_in;
    assign RamOut            = ctrl.ram_out;
    assign RamIn             = ctrl.ram_in;
    assign InstructionRegIn  = ctrl.ir_in;
    assign InstructionRegOut = ctrl.ir_out;
    assign AccIn             = ctrl.acc_in;
    assign AccOut            = ctrl.acc_out;
    assign BIn               = ctrl.b_in;
    assign AluOut            = ctrl.alu_out;
    assign AluSub            = ctrl.alu_sub;
    assign FlagsIn           = ctrl.flags_in;
    assign Step              = step_q;
    assign Halted            = (state_q == HALT);
    assign IllegalOp         = illegal_d;

`ifndef SYNTHESIS
    bus_one_driver: assert property (@(posedge Clk) disable iff (Rst)
        $onehot0(bus_drivers(ctrl)));
    step_in_range: assert property (@(posedge Clk) disable iff (Rst)
        step_q <= STEP_W'(4));
`endif

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer with a small datapath model that
// feeds OpCode back from a modelled instruction register.
module tb_cpu_control_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Run = 1'b1;
    logic [4:0]  OpCode;
    logic        ZeroFlag = 1'b0;
    logic        PcOut, PcIn, PcInc, MarIn, RamOut, RamIn;
    logic        InstructionRegIn, InstructionRegOut, AccIn, AccOut, BIn;
    logic        AluOut, AluSub, FlagsIn, Halted, IllegalOp;
    logic [2:0]  Step;

    int checks = 0;
    int fails  = 0;

    localparam logic [13:0] M_PCOUT   = 14'h2000, M_PCIN   = 14'h1000;
    localparam logic [13:0] M_PCINC   = 14'h0800, M_MARIN  = 14'h0400;
    localparam logic [13:0] M_RAMOUT  = 14'h0200, M_RAMIN  = 14'h0100;
    localparam logic [13:0] M_IRIN    = 14'h0080, M_IROUT  = 14'h0040;
    localparam logic [13:0] M_ACCIN   = 14'h0020, M_ACCOUT = 14'h0010;
    localparam logic [13:0] M_BIN     = 14'h0008, M_ALUOUT = 14'h0004;
    localparam logic [13:0] M_ALUSUB  = 14'h0002, M_FLAGSIN = 14'h0001;
    localparam logic [13:0] F0 = M_PCOUT | M_MARIN;
    localparam logic [13:0] F1 = M_RAMOUT | M_IRIN | M_PCINC;

    typedef struct packed {
        logic        run;
        logic        zf;
        logic [13:0] ctrl;
        logic [2:0]  step;
        logic        halted;
        logic        illegal;
    } exp_t;

    function automatic exp_t e(logic run, logic zf, logic [13:0] c, logic [2:0] s,
                               logic h, logic il);
        exp_t x;
        x = '{run, zf, c, s, h, il};
        return x;
    endfunction

    cpu_control_sequencer #(.OP_W(5), .STEP_W(3)) dut (
        .Clk(Clk), .Rst(Rst), .Run(Run), .OpCode(OpCode), .ZeroFlag(ZeroFlag),
        .PcOut(PcOut), .PcIn(PcIn), .PcInc(PcInc), .MarIn(MarIn),
        .RamOut(RamOut), .RamIn(RamIn), .InstructionRegIn(InstructionRegIn),
        .InstructionRegOut(InstructionRegOut), .AccIn(AccIn), .AccOut(AccOut),
        .BIn(BIn), .AluOut(AluOut), .AluSub(AluSub), .FlagsIn(FlagsIn),
        .Step(Step), .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    // Datapath model: RAM image is copied in while reset is held.
    logic [15:0] img [0:2047];
    logic [15:0] ram [0:2047];
    logic [10:0] pc, mar;
    logic [15:0] ir, acc, b, bus;
    logic [13:0] ctrl_obs;

    assign ctrl_obs = {PcOut, PcIn, PcInc, MarIn, RamOut, RamIn, InstructionRegIn,
                       InstructionRegOut, AccIn, AccOut, BIn, AluOut, AluSub, FlagsIn};
    assign OpCode = ir[15:11];

    always_comb begin
        bus = 16'h0000;
        if (PcOut)                  bus = {5'b0, pc};
        else if (RamOut)            bus = ram[mar];
        else if (InstructionRegOut) bus = {5'b0, ir[10:0]};
        else if (AccOut)            bus = acc;
        else if (AluOut)            bus = AluSub ? acc - b : acc + b;
    end

    always @(posedge Clk) begin
        if (Rst) begin
            pc <= '0; mar <= '0; ir <= '0; acc <= '0; b <= '0;
            for (int i = 0; i < 2048; i++) ram[i] <= img[i];
        end else begin
            if (PcIn) pc <= bus[10:0];
            else if (PcInc) pc <= pc + 11'd1;
            if (MarIn) mar <= bus[10:0];
            if (RamIn) ram[mar] <= bus;
            if (InstructionRegIn) ir <= bus;
            if (AccIn) acc <= bus;
            if (BIn) b <= bus;
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 2048; i++) img[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Run = 1'b1;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        checks++;
        if ({ctrl_obs, Step, Halted, IllegalOp} !== 19'd0)
            $display("FAIL reset_hold: got ctrl=%h step=%0d halted=%b ill=%b, want all 0",
                     ctrl_obs, Step, Halted, IllegalOp);
        if ({ctrl_obs, Step, Halted, IllegalOp} !== 19'd0) fails++;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (ctrl_obs !== F0 || Step !== 3'd0) begin
            $display("FAIL reset_release: got ctrl=%h step=%0d, want ctrl=%h step=0",
                     ctrl_obs, Step, F0);
            fails++;
        end
    endtask

    task automatic test_program();
        exp_t seq[$];
        clear_img();
        img[0] = 16'h3805;  // LDI 5
        img[1] = 16'h1810;  // ADD [0x10]
        img[2] = 16'hF800;  // HLT
        img[16] = 16'h0003;
        do_reset();
        seq = '{e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,M_IROUT|M_ACCIN,2,0,0),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,M_IROUT|M_MARIN,2,0,0),
                e(1,0,M_RAMOUT|M_BIN,3,0,0), e(1,0,M_ALUOUT|M_ACCIN|M_FLAGSIN,4,0,0),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,14'h0,2,0,0),
                e(1,0,14'h0,0,1,0), e(0,0,14'h0,0,1,0), e(1,0,14'h0,0,1,0)};
        for (int i = 0; i < seq.size(); i++) begin
            Run = seq[i].run; ZeroFlag = seq[i].zf;
            #1;
            checks++;
            if ({ctrl_obs, Step, Halted, IllegalOp} !==
                {seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal}) begin
                $display("FAIL program cycle %0d: got ctrl=%h step=%0d halted=%b ill=%b, want ctrl=%h step=%0d halted=%b ill=%b",
                         i + 1, ctrl_obs, Step, Halted, IllegalOp,
                         seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal);
                fails++;
            end
            @(negedge Clk);
        end
        checks++;
        if (acc !== 16'd8) begin
            $display("FAIL program_acc: got %0d, want 8", acc);
            fails++;
        end
    endtask

    task automatic test_sub();
        exp_t seq[$];
        clear_img();
        img[0] = 16'h3805;  // LDI 5
        img[1] = 16'h2010;  // SUB [0x10]
        img[16] = 16'h0003;
        do_reset();
        seq = '{e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,M_IROUT|M_ACCIN,2,0,0),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,M_IROUT|M_MARIN,2,0,0),
                e(1,0,M_RAMOUT|M_BIN,3,0,0),
                e(1,0,M_ALUOUT|M_ACCIN|M_FLAGSIN|M_ALUSUB,4,0,0), e(1,0,F0,0,0,0)};
        for (int i = 0; i < seq.size(); i++) begin
            Run = seq[i].run; ZeroFlag = seq[i].zf;
            #1;
            checks++;
            if ({ctrl_obs, Step, Halted, IllegalOp} !==
                {seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal}) begin
                $display("FAIL sub cycle %0d: got ctrl=%h step=%0d halted=%b ill=%b, want ctrl=%h step=%0d halted=%b ill=%b",
                         i + 1, ctrl_obs, Step, Halted, IllegalOp,
                         seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal);
                fails++;
            end
            @(negedge Clk);
        end
        checks++;
        if (acc !== 16'd2) begin
            $display("FAIL sub_acc: got %0d, want 2", acc);
            fails++;
        end
    endtask

    task automatic test_jz_jmp();
        exp_t seq[$];
        clear_img();
        img[0] = 16'h3005;  // JZ 5, not taken
        img[1] = 16'h3007;  // JZ 7, taken
        img[7] = 16'h2802;  // JMP 2
        do_reset();
        seq = '{e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,14'h0,2,0,0),
                e(1,1,F0,0,0,0), e(1,1,F1,1,0,0), e(1,1,M_IROUT|M_PCIN,2,0,0),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,M_IROUT|M_PCIN,2,0,0)};
        for (int i = 0; i < seq.size(); i++) begin
            Run = seq[i].run; ZeroFlag = seq[i].zf;
            #1;
            checks++;
            if ({ctrl_obs, Step, Halted, IllegalOp} !==
                {seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal}) begin
                $display("FAIL jz_jmp cycle %0d: got ctrl=%h step=%0d halted=%b ill=%b, want ctrl=%h step=%0d halted=%b ill=%b",
                         i + 1, ctrl_obs, Step, Halted, IllegalOp,
                         seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal);
                fails++;
            end
            @(negedge Clk);
        end
        checks++;
        if (pc !== 11'd2) begin
            $display("FAIL jmp_pc: got %0d, want 2", pc);
            fails++;
        end
    endtask

    task automatic test_illegal();
        exp_t seq[$];
        clear_img();
        img[0] = 16'h5000;  // opcode 0x0A
        do_reset();
        seq = '{e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,14'h0,2,0,1),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0), e(1,0,14'h0,2,0,0)};
        for (int i = 0; i < seq.size(); i++) begin
            Run = seq[i].run; ZeroFlag = seq[i].zf;
            #1;
            checks++;
            if ({ctrl_obs, Step, Halted, IllegalOp} !==
                {seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal}) begin
                $display("FAIL illegal cycle %0d: got ctrl=%h step=%0d halted=%b ill=%b, want ctrl=%h step=%0d halted=%b ill=%b",
                         i + 1, ctrl_obs, Step, Halted, IllegalOp,
                         seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal);
                fails++;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_run_pause();
        exp_t seq[$];
        clear_img();
        img[0] = 16'h1012;  // STA 0x12
        img[18] = 16'hFFFF;
        do_reset();
        seq = '{e(1,0,F0,0,0,0), e(0,0,F1,1,0,0), e(0,0,M_IROUT|M_MARIN,2,0,0),
                e(0,0,M_ACCOUT|M_RAMIN,3,0,0), e(0,0,14'h0,0,0,0), e(0,0,14'h0,0,0,0),
                e(1,0,F0,0,0,0), e(1,0,F1,1,0,0)};
        for (int i = 0; i < seq.size(); i++) begin
            Run = seq[i].run; ZeroFlag = seq[i].zf;
            #1;
            checks++;
            if ({ctrl_obs, Step, Halted, IllegalOp} !==
                {seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal}) begin
                $display("FAIL run_pause cycle %0d: got ctrl=%h step=%0d halted=%b ill=%b, want ctrl=%h step=%0d halted=%b ill=%b",
                         i + 1, ctrl_obs, Step, Halted, IllegalOp,
                         seq[i].ctrl, seq[i].step, seq[i].halted, seq[i].illegal);
                fails++;
            end
            @(negedge Clk);
        end
        checks++;
        if (ram[18] !== 16'h0000) begin
            $display("FAIL sta_store: got %h, want 0000", ram[18]);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        clear_img();
        img[0] = 16'h0810;  // LDA [0x10]
        img[16] = 16'h1234;
        Run = 1'b1;
        do_reset();
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (ctrl_obs !== (M_RAMOUT | M_ACCIN) || Step !== 3'd3) begin
            $display("FAIL lda_t3: got ctrl=%h step=%0d, want ctrl=%h step=3",
                     ctrl_obs, Step, M_RAMOUT | M_ACCIN);
            fails++;
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== 14'h0 || Step !== 3'd0) begin
            $display("FAIL reset_mid: got ctrl=%h step=%0d, want ctrl=0000 step=0",
                     ctrl_obs, Step);
            fails++;
        end
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (ctrl_obs !== F0 || Step !== 3'd0) begin
            $display("FAIL reset_mid_release: got ctrl=%h step=%0d, want ctrl=%h step=0",
                     ctrl_obs, Step, F0);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] drv;
        for (int i = 0; i < 2048; i++)
            img[i] = {5'($urandom_range(0, 30)), 11'($urandom_range(0, 2047))};
        Run = 1'b1;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            ZeroFlag = 1'($urandom_range(0, 1));
            #1;
            drv = {PcOut, RamOut, InstructionRegOut, AccOut, AluOut};
            checks++;
            if (!$onehot0(drv) || Step > 3'd4 || Halted !== 1'b0) begin
                $display("FAIL random cycle %0d: got drivers=%b step=%0d halted=%b, want onehot0 step<=4 halted=0",
                         c, drv, Step, Halted);
                fails++;
            end
            @(negedge Clk);
        end
    endtask

    initial begin
        clear_img();
        test_reset();
        test_program();
        test_sub();
        test_jz_jmp();
        test_illegal();
        test_run_pause();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
